mem_dp_strb: RTL

MEM_DP_STRB -- requirements
Module: mem_dp_strb

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_rsp_pipe.sv | 47 ++++
 rtl/mem_dp_strb.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-port byte-strobed memory.
package mem_pkg;

  // Controller states: clearing the array after reset, then serving both ports.
  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } mem_state_t;

  // One byte lane of a strobed write: take the new byte when its strobe is set.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       strobe);
    return strobe ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Response delay line: carries valid/data/err LATENCY cycles after accept.
module mem_rsp_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vld_p0,
  input  logic [DATA_WIDTH-1:0] data_p0,
  input  logic                  err_p0,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
);

  logic                  vld_p  [LATENCY];
  logic [DATA_WIDTH-1:0] data_p [LATENCY];
  logic                  err_p  [LATENCY];

  // Valid chain: reset drops every response still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= vld_p0;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Payload chain: no reset needed, outputs are masked by valid.
  always_ff @(posedge clk) begin
    data_p[0] <= data_p0;
    err_p[0]  <= err_p0;
    for (int i = 1; i < LATENCY; i++) begin
      data_p[i] <= data_p[i-1];
      err_p[i]  <= err_p[i-1];
    end
  end

  // Final stage: rdata and err read as zero whenever no response is presented.
  always_comb begin
    rvalid = vld_p[LATENCY-1];
    rdata  = rvalid ? data_p[LATENCY-1] : '0;
    err    = rvalid & err_p[LATENCY-1];
  end

endmodule

// File: rtl/mem_dp_strb.sv
// Dual-port word memory: port A fetch-only, port B read/write with byte
// strobes. Cleared word-by-word after reset before either port is granted.
module mem_dp_strb
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_req,
  input  logic [31:0]             a_addr,
  output logic                    a_gnt,
  output logic                    a_rvalid,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_err,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic [31:0]             b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic                    b_gnt,
  output logic                    b_rvalid,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_err,
  output logic                    init_done
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BE_W);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  mem_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] a_idx, b_idx;
  logic                  a_bad, b_bad;
  logic                  a_acc, b_acc, b_wr;
  logic [DATA_WIDTH-1:0] b_merged;
  logic [DATA_WIDTH-1:0] a_data_p0, b_data_p0;

  // Misaligned byte offset or any address bit beyond the array is an error.
  function automatic logic addr_err(input logic [31:0] addr);
    return (addr[OFF-1:0] != '0) || ((addr >> (OFF + ADDR_WIDTH)) != 32'd0);
  endfunction

  // State register and clear counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Next state: leave INIT once the last word has been cleared.
  always_comb begin
    state_d = state_q;
    if (state_q == INIT && clr_cnt == '1) state_d = READY;
  end

  // FSM outputs: grants only while READY.
  always_comb begin
    init_done = (state_q == READY);
    a_gnt     = a_req && init_done;
    b_gnt     = b_req && init_done;
  end

  // Address decode and accept qualification.
  always_comb begin
    a_idx = a_addr[OFF +: ADDR_WIDTH];
    b_idx = b_addr[OFF +: ADDR_WIDTH];
    a_bad = addr_err(a_addr);
    b_bad = addr_err(b_addr);
    a_acc = a_req && a_gnt;
    b_acc = b_req && b_gnt;
    b_wr  = b_acc && b_we && !b_bad;
  end

  // Byte-strobed merge of port B write data into the addressed word.
  always_comb begin
    b_merged = mem[b_idx];
    for (int i = 0; i < BE_W; i++)
      b_merged[8*i +: 8] = merge_byte(mem[b_idx][8*i +: 8], b_wdata[8*i +: 8], b_be[i]);
  end

  // Single write port: INIT clearing has priority over port B.
  always_ff @(posedge clk) begin
    if (state_q == INIT) mem[clr_cnt] <= '0;
    else if (b_wr)       mem[b_idx]   <= b_merged;
  end

  // Stage p0: response payload captured at the accept edge.
  always_comb begin
    a_data_p0 = '0;
    if (!a_bad) begin
      if (RDW_MODE == 1 && b_wr && b_idx == a_idx) a_data_p0 = b_merged;
      else                                         a_data_p0 = mem[a_idx];
    end
    b_data_p0 = '0;
    if (!b_bad && !b_we) b_data_p0 = mem[b_idx];
  end

  mem_rsp_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_a_pipe (
    .clk     (clk),
    .reset   (reset),
    .vld_p0  (a_acc),
    .data_p0 (a_data_p0),
    .err_p0  (a_bad),
    .rvalid  (a_rvalid),
    .rdata   (a_rdata),
    .err     (a_err)
  );

  mem_rsp_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_b_pipe (
    .clk     (clk),
    .reset   (reset),
    .vld_p0  (b_acc),
    .data_p0 (b_data_p0),
    .err_p0  (b_bad),
    .rvalid  (b_rvalid),
    .rdata   (b_rdata),
    .err     (b_err)
  );

endmodule
